// File: rtl/bus_arb_nxm.sv
// N-master / M-slave bus arbiter: round-robin grant with optional hold limit, region decode, registered read return.
// Latency: grant 1 cycle after request; read data and M_rvalid 1 cycle after the command; decode_err 1 cycle after.
// Backpressure: none on the data path; losing masters wait until granted. BUS_ERR_RESP_EN enables the error response.
module bus_arb_nxm #(
    parameter int N_MASTERS = 2,
    parameter int N_SLAVES  = 4,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int REGION_W  = 5,
    parameter int MAX_HOLD  = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [N_MASTERS-1:0]          M_req,
    input  logic [N_MASTERS-1:0]          M_wr,
    input  logic [N_MASTERS*ADDR_W-1:0]   M_address,
    input  logic [N_MASTERS*DATA_W-1:0]   M_dout,
    output logic [N_MASTERS-1:0]          M_grant,
    output logic [DATA_W-1:0]             M_din,
    output logic                          M_rvalid,
    output logic [N_SLAVES-1:0]           S_sel,
    output logic                          S_wr,
    output logic [ADDR_W-1:0]             S_address,
    output logic [DATA_W-1:0]             S_din,
    input  logic [N_SLAVES*DATA_W-1:0]    S_dout,
    output logic                          decode_err
);
    localparam int OW_W   = $clog2(N_MASTERS);
    localparam int IDX_W  = ADDR_W - REGION_W;
    localparam int HOLD_W = 16;
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t              state, state_d;
    logic [OW_W-1:0]     owner, owner_d, last_owner, last_d;
    logic [HOLD_W-1:0]   hold_cnt, hold_d;
    logic [OW_W-1:0]     pick_all, pick_oth;
    logic                any_all, any_oth;
    logic [N_MASTERS-1:0] own_oh;
    logic                own_req, own_wr, cmd_vld, in_range;
    logic [ADDR_W-1:0]   own_addr;
    logic [DATA_W-1:0]   own_dat;
    logic [IDX_W-1:0]    idx;
    logic [N_SLAVES-1:0] rd_sel;
    logic                rvalid_q;

    // First requester found scanning upward from last+1 with wrap, over 'span' candidates.
    function automatic logic [OW_W-1:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                                input logic [OW_W-1:0] last,
                                                input int span, output logic found);
        logic [OW_W-1:0]      pick;
        logic [N_MASTERS-1:0] req_sh;
        int                   c;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            c      = (int'(last) + 1 + i) % N_MASTERS;
            req_sh = req >> c;
            if (i < span && !found && req_sh[0]) begin
                found = 1'b1;
                pick  = OW_W'(c);
            end
        end
        return pick;
    endfunction

    always_comb begin
        state_d  = state;
        owner_d  = owner;
        last_d   = last_owner;
        hold_d   = hold_cnt;
        pick_all = rr_pick(M_req, last_owner, N_MASTERS, any_all);
        // last_owner equals owner while OWNED, so this scan excludes the current owner.
        pick_oth = rr_pick(M_req, last_owner, N_MASTERS - 1, any_oth);
        case (state)
            IDLE: begin
                if (any_all) begin
                    state_d = OWNED;
                    owner_d = pick_all;
                    last_d  = pick_all;
                    hold_d  = '0;
                end
            end
            OWNED: begin
                if (!own_req) begin
                    hold_d = '0;
                    if (any_oth) begin
                        owner_d = pick_oth;
                        last_d  = pick_oth;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (MAX_HOLD > 0 && hold_cnt == HOLD_LIM && any_oth) begin
                    owner_d = pick_oth;
                    last_d  = pick_oth;
                    hold_d  = '0;
                end else if (MAX_HOLD == 0 || hold_cnt != HOLD_LIM) begin
                    hold_d = hold_cnt + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= OW_W'(N_MASTERS - 1);
            hold_cnt   <= '0;
            rd_sel     <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            state      <= state_d;
            owner      <= owner_d;
            last_owner <= last_d;
            hold_cnt   <= hold_d;
            rd_sel     <= (cmd_vld && !own_wr) ? S_sel : '0;
`ifdef BUS_ERR_RESP_EN
            rvalid_q   <= cmd_vld && !own_wr;
`else
            rvalid_q   <= cmd_vld && !own_wr && in_range;
`endif
        end
    end

    always_comb begin
        own_oh   = N_MASTERS'(1) << owner;
        own_req  = |(M_req & own_oh);
        own_wr   = |(M_wr & own_oh);
        own_addr = '0;
        own_dat  = '0;
        for (int m = 0; m < N_MASTERS; m++) begin
            if (own_oh[m]) begin
                own_addr = M_address[m*ADDR_W +: ADDR_W];
                own_dat  = M_dout[m*DATA_W +: DATA_W];
            end
        end
        cmd_vld  = (state == OWNED) && own_req;
        idx      = own_addr[ADDR_W-1:REGION_W];
        in_range = int'(idx) < N_SLAVES;
        for (int k = 0; k < N_SLAVES; k++) begin
            S_sel[k] = cmd_vld && (int'(idx) == k);
        end
        S_wr      = cmd_vld && own_wr;
        S_address = cmd_vld ? own_addr : '0;
        S_din     = cmd_vld ? own_dat : '0;
        M_grant   = (state == OWNED) ? own_oh : '0;
    end

`ifdef BUS_ERR_RESP_EN
    localparam logic [DATA_W-1:0] ERR_DAT = DATA_W'(32'hDEAD_BEEF);
    logic rd_err, derr_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_err <= 1'b0;
            derr_q <= 1'b0;
        end else begin
            rd_err <= cmd_vld && !own_wr && !in_range;
            derr_q <= cmd_vld && !in_range;
        end
    end
    assign decode_err = derr_q;
`endif

    // Read data comes straight off the slave selected last cycle; zero when nothing is returning.
    always_comb begin
        M_din = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (rd_sel[k]) M_din = M_din | S_dout[k*DATA_W +: DATA_W];
        end
`ifdef BUS_ERR_RESP_EN
        if (rd_err) M_din = ERR_DAT;
`else
        decode_err = 1'b0;
`endif
    end

    assign M_rvalid = rvalid_q;
endmodule

// File: tb/tb_bus_arb_nxm.sv
// Scoreboarded bench for bus_arb_nxm: directed bus sequences, a 4-slave memory model,
// and a second instance with MAX_HOLD=4 for the forced-handover pattern.
module tb_bus_arb_nxm;
    logic         clk = 1'b0;
    logic         reset_n;
    logic [1:0]   req, wr;
    logic [15:0]  addr;
    logic [63:0]  dout;
    logic [1:0]   grant;
    logic [31:0]  din;
    logic         rvalid;
    logic [3:0]   s_sel;
    logic         s_wr;
    logic [7:0]   s_addr;
    logic [31:0]  s_din;
    logic [127:0] s_dout;
    logic         derr;

    logic [1:0]   h_req, h_wr;
    logic [15:0]  h_addr;
    logic [63:0]  h_dout;
    logic [127:0] h_sdout;
    logic [1:0]   h_grant;
    logic [31:0]  h_din;
    logic         h_rvalid, h_swr, h_derr;
    logic [3:0]   h_sel;
    logic [7:0]   h_saddr;
    logic [31:0]  h_sdin;

    logic [31:0]  mem [4][32];
    logic [31:0]  sdq [4];
    logic [31:0]  exp_q [$];
    int           n_chk = 0;
    int           n_fail = 0;
    logic         mon_en = 1'b0;

    always #5 clk = ~clk;

    bus_arb_nxm u_dut (
        .clk(clk), .reset_n(reset_n), .M_req(req), .M_wr(wr), .M_address(addr), .M_dout(dout),
        .M_grant(grant), .M_din(din), .M_rvalid(rvalid), .S_sel(s_sel), .S_wr(s_wr),
        .S_address(s_addr), .S_din(s_din), .S_dout(s_dout), .decode_err(derr)
    );

    bus_arb_nxm #(.MAX_HOLD(4)) u_dut_hold (
        .clk(clk), .reset_n(reset_n), .M_req(h_req), .M_wr(h_wr), .M_address(h_addr), .M_dout(h_dout),
        .M_grant(h_grant), .M_din(h_din), .M_rvalid(h_rvalid), .S_sel(h_sel), .S_wr(h_swr),
        .S_address(h_saddr), .S_din(h_sdin), .S_dout(h_sdout), .decode_err(h_derr)
    );

    // Slave k: 32 words, synchronous read with one cycle of latency.
    initial begin
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 32; i++)
                mem[k][i] = 32'h5000_0000 + k * 256 + i;
        mem[1][5] = 32'h0000_1234;
        for (int k = 0; k < 4; k++) sdq[k] = '0;
    end

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (s_sel[k]) begin
                if (s_wr) mem[k][s_addr[4:0]] <= s_din;
                sdq[k] <= mem[k][s_addr[4:0]];
            end
        end
    end
    assign s_dout = {sdq[3], sdq[2], sdq[1], sdq[0]};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every returned word must match the oldest expected read.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rvalid) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got %0h, expected no return at %0t", din, $time);
                end else begin
                    chk("rd_data", {32'h0, din}, {32'h0, exp_q.pop_front()});
                end
            end else begin
                chk("din_idle_zero", {32'h0, din}, 64'h0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int m, input logic r, input logic w, input logic [7:0] a,
                         input logic [31:0] d);
        req[m] = r;
        wr[m] = w;
        addr[m*8 +: 8] = a;
        dout[m*32 +: 32] = d;
    endtask

    initial begin
        reset_n = 1'b0;
        req = '0; wr = '0; addr = '0; dout = '0;
        h_req = '0; h_wr = '0; h_addr = '0; h_dout = '0; h_sdout = '0;
        set_m(0, 1'b1, 1'b0, 8'h25, 32'h0);
        set_m(1, 1'b1, 1'b0, 8'h61, 32'h0);
        step(); step();
        #3;
        chk("rst_grant", {62'h0, grant}, 64'h0);
        chk("rst_rvalid", {63'h0, rvalid}, 64'h0);
        chk("rst_din", {32'h0, din}, 64'h0);
        chk("rst_derr", {63'h0, derr}, 64'h0);
        mon_en = 1'b1;
        // C0: release reset
        step(); reset_n = 1'b1; #3;
        chk("grant_c0", {62'h0, grant}, 64'h0);
        // C1: M0 wins first, reads 0x25 from slave 1
        step(); #3;
        chk("grant_c1", {62'h0, grant}, 64'h1);
        chk("sel_c1", {60'h0, s_sel}, 64'h2);
        exp_q.push_back(32'h0000_1234);
        // C2: back-to-back read of slave 0
        step(); set_m(0, 1'b1, 1'b0, 8'h03, 32'h0); #3;
        chk("grant_c2", {62'h0, grant}, 64'h1);
        chk("sel_c2", {60'h0, s_sel}, 64'h1);
        exp_q.push_back(32'h5000_0003);
        // C3: M0 drops; grant still shown, no command
        step(); set_m(0, 1'b0, 1'b0, 8'h03, 32'h0); #3;
        chk("grant_c3", {62'h0, grant}, 64'h1);
        chk("sel_c3", {60'h0, s_sel}, 64'h0);
        // C4: M1 takes over with no idle cycle
        step(); #3;
        chk("grant_c4", {62'h0, grant}, 64'h2);
        chk("sel_c4", {60'h0, s_sel}, 64'h8);
        exp_q.push_back(32'h5000_0301);
        // C5-C6: M0 re-requests but M1 keeps the bus
        step(); set_m(0, 1'b1, 1'b1, 8'h40, 32'hA5A5_0001); #3;
        chk("grant_c5", {62'h0, grant}, 64'h2);
        chk("addr_c5", {56'h0, s_addr}, 64'h61);
        exp_q.push_back(32'h5000_0301);
        step(); #3;
        chk("grant_c6", {62'h0, grant}, 64'h2);
        exp_q.push_back(32'h5000_0301);
        // C7: M1 drops
        step(); set_m(1, 1'b0, 1'b0, 8'h61, 32'h0); #3;
        chk("grant_c7", {62'h0, grant}, 64'h2);
        chk("sel_c7", {60'h0, s_sel}, 64'h0);
        // C8: M0 writes 0x40
        step(); #3;
        chk("grant_c8", {62'h0, grant}, 64'h1);
        chk("wr_sel", {60'h0, s_sel}, 64'h4);
        chk("wr_addr", {56'h0, s_addr}, 64'h40);
        chk("wr_en", {63'h0, s_wr}, 64'h1);
        chk("wr_din", {32'h0, s_din}, 64'hA5A5_0001);
        // C9: read it back
        step(); set_m(0, 1'b1, 1'b0, 8'h40, 32'h0); #3;
        chk("rd_en_c9", {63'h0, s_wr}, 64'h0);
        exp_q.push_back(32'hA5A5_0001);
        // C10: out-of-range read
        step(); set_m(0, 1'b1, 1'b0, 8'h80, 32'h0); #3;
        chk("oor_sel", {60'h0, s_sel}, 64'h0);
        chk("derr_c10", {63'h0, derr}, 64'h0);
`ifdef BUS_ERR_RESP_EN
        exp_q.push_back(32'hDEAD_BEEF);
`endif
        // C11
        step(); set_m(0, 1'b0, 1'b0, 8'h80, 32'h0); #3;
`ifdef BUS_ERR_RESP_EN
        chk("derr_c11", {63'h0, derr}, 64'h1);
`else
        chk("derr_c11", {63'h0, derr}, 64'h0);
`endif
        chk("grant_c11", {62'h0, grant}, 64'h1);
        // C12: bus goes idle, M1 requests
        step(); set_m(1, 1'b1, 1'b0, 8'h21, 32'h0); #3;
        chk("grant_c12", {62'h0, grant}, 64'h0);
        chk("derr_c12", {63'h0, derr}, 64'h0);
        // C13: M1 owns with a read issued; reset hits at the next edge
        step(); reset_n = 1'b0; #3;
        chk("grant_c13", {62'h0, grant}, 64'h2);
        chk("sel_c13", {60'h0, s_sel}, 64'h2);
        // C14: in reset, read return discarded
        step(); reset_n = 1'b1; set_m(0, 1'b1, 1'b0, 8'h03, 32'h0); #3;
        chk("rst2_grant", {62'h0, grant}, 64'h0);
        chk("rst2_rvalid", {63'h0, rvalid}, 64'h0);
        chk("rst2_din", {32'h0, din}, 64'h0);
        // C15: M0 wins first after reset despite M1 requesting
        step(); #3;
        chk("grant_c15", {62'h0, grant}, 64'h1);
        exp_q.push_back(32'h5000_0003);
        step(); set_m(0, 1'b0, 1'b0, 8'h0, 32'h0); set_m(1, 1'b0, 1'b0, 8'h0, 32'h0);
        // Hold-limited instance: both request continuously
        step(); h_req = 2'b11;
        for (int i = 1; i <= 12; i++) begin
            step(); #3;
            chk($sformatf("hold_grant_%0d", i), {62'h0, h_grant},
                (i <= 4) ? 64'h1 : (i <= 8) ? 64'h2 : 64'h1);
        end
        h_req = 2'b00;
        step(); step(); step();
        chk("exp_q_drained", 64'(exp_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_arb_nxm.md
Name: bus_arb_nxm

Overview:
- Parametrised successor to the fixed 2-master/4-slave system bus.
- Connects N_MASTERS requesters to N_SLAVES memory-mapped slaves: the host port, the matrix engine's DMA master, and the A/B/result RAMs plus future accelerators.
- Adds round-robin arbitration with an optional hold limit, parametrised address decode, a registered read-return path with a valid strobe, and decode-error signalling.

Parameters:
- N_MASTERS, 2, number of masters (2..4).
- N_SLAVES, 4, number of slaves (1..8).
- ADDR_W, 8, address width.
- DATA_W, 32, data width.
- REGION_W, 5, log2 of the slave region size. Slave index = address[ADDR_W-1:REGION_W]; slave k owns addresses k*2^REGION_W .. (k+1)*2^REGION_W-1.
- MAX_HOLD, 0, maximum consecutive granted cycles before forced handover when another master is waiting; 0 = unlimited.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- M_req  in  N_MASTERS  per-master request.
- M_wr  in  N_MASTERS  per-master write (1) / read (0).
- M_address  in  N_MASTERS*ADDR_W  master m at bits [m*ADDR_W +: ADDR_W].
- M_dout  in  N_MASTERS*DATA_W  master write data, packed the same way.
- M_grant  out  N_MASTERS  one-hot-or-zero grant, registered.
- M_din  out  DATA_W  read data returned to the owner.
- M_rvalid  out  1  M_din valid strobe.
- S_sel  out  N_SLAVES  one-hot slave select.
- S_wr  out  1  write enable to slaves.
- S_address  out  ADDR_W  address to slaves (full width; slaves use low bits).
- S_din  out  DATA_W  write data to slaves.
- S_dout  in  N_SLAVES*DATA_W  slave read data; slaves have 1-cycle synchronous read latency.
- decode_err  out  1  out-of-range access pulse.

Behaviour:
- Reset (reset_n=0 at a clk edge): M_grant=0, M_rvalid=0, M_din=0, decode_err=0, hold counter=0. The last-owner pointer is set to N_MASTERS-1 so master 0 has first priority. Reset mid-transfer drops the grant immediately; the pending read return is discarded.
- FSM has two states, IDLE and OWNED. The owner index is registered.
  - IDLE: if any M_req is set, select a winner round-robin, searching from last_owner+1 upward with wrap-around. Next cycle: OWNED, M_grant[winner]=1. Grant latency from first request = 1 cycle.
  - OWNED, owner req=1: hold the grant. The hold counter increments each cycle.
  - OWNED, forced handover: if MAX_HOLD>0, counter==MAX_HOLD-1 and another master is requesting, grant the next round-robin requester the next cycle (no bubble) and clear the counter.
  - OWNED, owner req=0: the next cycle grants the next round-robin requester excluding the old owner, or returns to IDLE if none is requesting. last_owner is updated on every grant change.
- Command path (combinational from owner signals, valid only when OWNED and owner M_req=1; otherwise all 0):
  - S_address = owner address, S_wr = owner wr, S_din = owner dout.
  - S_sel[idx]=1 only if idx < N_SLAVES.
- A master's signals are ignored in any cycle it is not granted.
- Read return:
  - A read command in cycle t (S_sel nonzero, S_wr=0) registers the slave index.
  - In cycle t+1: M_rvalid=1 and M_din = S_dout of that slave.
  - Back-to-back reads give one result per cycle, including across an ownership change.
  - Writes produce no M_rvalid.
  - M_din=0 whenever M_rvalid=0.
- Out-of-range address (idx >= N_SLAVES) with req active: no S_sel, and decode_err=1 registered in the following cycle. The return behaviour is set by the optional feature.
- Simultaneous owner-drop and new requests resolve by round-robin only. There is no fixed priority beyond reset.

Optional Feature:
- Macro BUS_ERR_RESP_EN.
- Defined: an out-of-range read returns M_rvalid=1 with M_din=32'hDEAD_BEEF (truncated/zero-extended to DATA_W) in cycle t+1; decode_err pulses for out-of-range reads and writes.
- Undefined: decode_err is tied 0; an out-of-range access gives no M_rvalid and M_din stays 0.

Test Plan:
- Reset with M_req=2'b11 held → cycle after release M_grant=2'b01; M0 read 0x25 to slave1 holding 0x1234 → next cycle M_rvalid=1, M_din=32'h1234.
- Both masters request continuously, M0 drops after 3 cycles → M_grant 01 for 3 cycles then 10 with no idle cycle; M0 re-requests → regrant only after M1 drops.
- MAX_HOLD=4, both request continuously → grant alternates 01×4, 10×4, 01×4.
- M0 writes 32'hA5A5_0001 to 0x40 → S_sel=4'b0100, S_address=0x40, S_wr=1, S_din matches, M_rvalid stays 0; read back → 32'hA5A5_0001.
- Read 0x80 with N_SLAVES=4 → S_sel=0. With BUS_ERR_RESP_EN: decode_err=1 and M_din=32'hDEADBEEF next cycle. Without it: decode_err=0 and M_rvalid=0.
- reset_n=0 while M1 owned with read in flight → next cycle M_grant=0, M_rvalid=0, M_din=0; after release, M0 wins first.
